aes_sched: RTL and testbench
============================

// Module: aes_sched
// PURPOSE
//  Iterative round scheduler sharing one combinational AES round engine between two requesters.
//  Arbitrates, captures a 128-bit block, drives engine state/round index for NR+1 cycles, returns result.
//  Sits between bus-side requesters and the round engine; round keys come from aes_kexp (KExp) via eng_round.
// PARAMETERS
//  NR   10   number of rounds (10/12/14 for AES-128/192/256); eng_round indexes 0..NR
//  NB    4   state columns; block width = 32*NB = 128
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    reset, asynchronous, active-high
//  req0_valid   in   1    requester 0 block valid
//  req0_ready   out  1    requester 0 accepted this cycle
//  req0_dec     in   1    0=encrypt, 1=decrypt
//  req0_data    in   128  input block
//  req1_valid/req1_ready/req1_dec/req1_data   same as requester 0
//  eng_state    out  128  current state register to engine
//  eng_round    out  4    round-key index to engine (enc: cnt, dec: NR-cnt)
//  eng_dec      out  1    latched mode of active job
//  eng_result   in   128  engine output for (eng_state, eng_round, eng_dec), combinational
//  rsp_valid    out  1    result valid
//  rsp_ready    in   1    consumer ready
//  rsp_data     out  128  result block
//  rsp_src      out  1    requester id of result
// BEHAVIOUR
//  Reset (async): state IDLE, cnt=0, eng_state=0, eng_dec=0, rsp_valid=0, rsp_src=0, last_grant=1, reqX_ready=0.
//  FSM IDLE -> RUN -> HOLD -> IDLE.
//  IDLE: reqX_ready = grant[X] (combinational, only in IDLE); on handshake load eng_state=reqX_data,
//   eng_dec=reqX_dec, rsp_src=X, cnt=0, last_grant=X, go RUN.
//  RUN: each edge eng_state<=eng_result, cnt++; edge at cnt==NR -> HOLD (cnt remains NR).
//  Latency: rsp_valid rises NR+1 clk edges after the accept edge (11 for NR=10).
//  HOLD: rsp_valid=1, rsp_data=eng_state held stable; on rsp_valid&rsp_ready -> IDLE next edge.
//   No request accepted in HOLD; one-cycle IDLE bubble between jobs (throughput 1 block / NR+3 cycles).
//  Arbitration (default): round-robin; both valid -> grant the one != last_grant; one valid -> it.
//   After reset req0 wins the first tie.
//  Inputs sampled only at handshake; reqX_data/dec need not stay stable after ready.
//  Withdrawing reqX_valid while not ready is allowed; no grant is remembered.
//  Mode change of the other requester mid-job has no effect; eng_dec held for whole job.
//  Reset mid-RUN/HOLD: job dropped, no rsp_valid produced, first grant after reset follows reset rules.
//  rsp_ready held high at entry to HOLD: handshake completes in HOLD's first cycle.
//  cnt is 4 bits; NR<=14 guaranteed; no wrap.
// CONFIGURATION
//  AES_SCHED_STRICT_PRIO_EN defined: fixed priority, req0 always wins when valid; last_grant unused.
//  Not defined: round-robin as above.
// STRUCTURE
//  aes_const: NR/NB reuse existing Nr/Nb constants.
//  aes_wire: typedef enum logic [1:0] {SCHED_IDLE, SCHED_RUN, SCHED_HOLD} aes_sched_state_t.
//  Sub-module aes_rr_arb: 2-way arbiter (valid[1:0], last_grant -> grant[1:0]), macro handled inside.
// TESTING
//  FIPS-197 C.1: req0 enc 00112233445566778899aabbccddeeff, key 000102..0f -> rsp_data
//   69c4e0d86a7b0430d8cdb78070b4c55a, rsp_src=0, rsp_valid exactly 11 cycles after accept.
//  req1 dec 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff, rsp_src=1;
//   eng_round sequence 10,9,...,0.
//  Both valid continuously, 4 jobs: grants 0,1,0,1 (round-robin); with AES_SCHED_STRICT_PRIO_EN 0,0,0,0.
//  rsp_ready low 5 cycles in HOLD: rsp_data stable, both reqX_ready=0, no new accept until after rsp handshake.
//  rst pulse at cnt=4: all outputs zero asynchronously, no rsp; next tie granted to req0.
//  req0_valid pulsed 1 cycle while job running: never accepted, no response appears.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES round scheduler.
//   AES_NR / AES_NB : default round count and state column count (AES-128)
//   aes_sched_state_t : scheduler FSM encoding
//   aes_round_idx() : maps the job-local round counter onto the round-key
//                     index the engine expects (ascending for encrypt,
//                     descending for decrypt).
package aes_sched_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NB = 4;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_RUN  = 2'd1,
    SCHED_HOLD = 2'd2
  } aes_sched_state_t;

  function automatic logic [3:0] aes_round_idx(input logic [3:0] cnt,
                                               input logic [3:0] nr,
                                               input logic       dec);
    return dec ? (nr - cnt) : cnt;
  endfunction

endpackage

// File: rtl/aes_rr_arb.sv
// Two-way request arbiter for the AES round scheduler.
//   valid[1:0]  : request valids from requester 0 and 1
//   last_grant  : requester that won the previous arbitration
//   grant[1:0]  : one-hot (or zero) grant, purely combinational
// Build option:
//   AES_SCHED_STRICT_PRIO_EN defined : requester 0 always wins when valid,
//                                      last_grant is ignored.
//   undefined (default)              : round-robin, a tie goes to the
//                                      requester that did not win last.
module aes_rr_arb (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef AES_SCHED_STRICT_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = 2'b00;
    if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end
`else
  always_comb begin
    grant = valid;
    // On a tie, hand the engine to whoever did not have it last time.
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end
`endif

endmodule

// File: rtl/aes_sched.sv
// Iterative round scheduler: shares one combinational AES round engine
// between two requesters. A granted block is captured into the state
// register, pushed through the engine for NR+1 consecutive cycles (round
// key index 0..NR for encrypt, NR..0 for decrypt) and then held on the
// response port until the consumer takes it.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   reqX_valid/ready/dec/data     : requester X block handshake (X = 0, 1)
//   eng_state/eng_round/eng_dec   : operands driven to the round engine
//   eng_result                    : engine output (combinational)
//   rsp_valid/ready/data/src      : result handshake and originating requester
// Build option: AES_SCHED_STRICT_PRIO_EN selects fixed priority (requester 0
// wins) inside aes_rr_arb; the default is round-robin.
module aes_sched
  import aes_sched_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int NB = AES_NB
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_dec,
  input  logic [32*NB-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_dec,
  input  logic [32*NB-1:0] req1_data,
  output logic [32*NB-1:0] eng_state,
  output logic [3:0]      eng_round,
  output logic            eng_dec,
  input  logic [32*NB-1:0] eng_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [32*NB-1:0] rsp_data,
  output logic            rsp_src
);

  localparam int         BLK_W = 32 * NB;
  localparam logic [3:0] NR_L  = 4'(NR);

  aes_sched_state_t   state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BLK_W-1:0]   eng_state_q, eng_state_d;
  logic               eng_dec_q, eng_dec_d;
  logic               rsp_src_q, rsp_src_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               last_grant_q, last_grant_d;
  logic [1:0]         grant;

  aes_rr_arb u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Ready is only offered while idle; gating with rst keeps it low while
  // reset is asserted even though the FSM already sits in IDLE.
  assign req0_ready = (state_q == SCHED_IDLE) && grant[0] && !rst;
  assign req1_ready = (state_q == SCHED_IDLE) && grant[1] && !rst;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    eng_state_d  = eng_state_q;
    eng_dec_d    = eng_dec_q;
    rsp_src_d    = rsp_src_q;
    rsp_valid_d  = rsp_valid_q;
    last_grant_d = last_grant_q;
    case (state_q)
      SCHED_IDLE: begin
        if (grant[0]) begin
          eng_state_d  = req0_data;
          eng_dec_d    = req0_dec;
          rsp_src_d    = 1'b0;
          last_grant_d = 1'b0;
          cnt_d        = 4'd0;
          state_d      = SCHED_RUN;
        end else if (grant[1]) begin
          eng_state_d  = req1_data;
          eng_dec_d    = req1_dec;
          rsp_src_d    = 1'b1;
          last_grant_d = 1'b1;
          cnt_d        = 4'd0;
          state_d      = SCHED_RUN;
        end
      end
      SCHED_RUN: begin
        eng_state_d = eng_result;
        // The final round is still applied on the cnt==NR edge; cnt then
        // parks at NR rather than wrapping.
        if (cnt_q == NR_L) begin
          state_d     = SCHED_HOLD;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SCHED_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = SCHED_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = SCHED_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SCHED_IDLE;
      cnt_q        <= 4'd0;
      eng_state_q  <= '0;
      eng_dec_q    <= 1'b0;
      rsp_src_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      eng_state_q  <= eng_state_d;
      eng_dec_q    <= eng_dec_d;
      rsp_src_q    <= rsp_src_d;
      rsp_valid_q  <= rsp_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign eng_state = eng_state_q;
  assign eng_dec   = eng_dec_q;
  assign eng_round = aes_round_idx(cnt_q, NR_L, eng_dec_q);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = eng_state_q;
  assign rsp_src   = rsp_src_q;

endmodule

// File: tb/tb_aes_sched.sv
// Bench for aes_sched: supplies an AES-128 round engine (tables derived from
// GF(2^8) arithmetic, FIPS-197 key schedule for key 000102..0f), a reference
// model of the whole cipher per accepted job, and a cycle-level scoreboard of
// grants, response timing and result data.
module tb_aes_sched;

  localparam int NR = 10;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_dec, req1_valid, req1_dec, rsp_ready;
  logic [127:0] req0_data, req1_data;
  logic         req0_ready, req1_ready, eng_dec, rsp_valid, rsp_src;
  logic [127:0] eng_state, eng_result, rsp_data;
  logic [3:0]   eng_round;

  aes_sched #(.NR(NR), .NB(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_dec   (req0_dec),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_dec   (req1_dec),
    .req1_data  (req1_data),
    .eng_state  (eng_state),
    .eng_round  (eng_round),
    .eng_dec    (eng_dec),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_src    (rsp_src)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AES arithmetic ----------------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [11];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, b, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] sub_b(input logic [127:0] s, input logic inv);
    for (int i = 0; i < 16; i++)
      s[8*i +: 8] = inv ? isbox[s[8*i +: 8]] : sbox[s[8*i +: 8]];
    return s;
  endfunction

  // Byte n of the block sits at row n%4, column n/4.
  function automatic logic [127:0] shift_r(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int sc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*sc) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    o = '0;
    if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(j+4*c) -: 8];
      for (int k = 0; k < 4; k++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j-k+4)%4], a[j]);
        o[127-8*(k+4*c) -: 8] = acc;
      end
    end
    return o;
  endfunction

  // One engine step for round-key index r.
  function automatic logic [127:0] eng_fn(input logic [127:0] s, input logic [3:0] r, input logic dec);
    if (r > 4'd10) return s;
    if (!dec) begin
      if (r == 4'd0) return s ^ rk[0];
      s = shift_r(sub_b(s, 1'b0), 1'b0);
      if (r != 4'd10) s = mix_c(s, 1'b0);
      return s ^ rk[r];
    end
    if (r == 4'd10) return s ^ rk[10];
    s = sub_b(shift_r(s, 1'b1), 1'b1) ^ rk[r];
    if (r != 4'd0) s = mix_c(s, 1'b1);
    return s;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] d, input logic dec);
    for (int i = 0; i <= NR; i++) d = eng_fn(d, dec ? 4'(NR - i) : 4'(i), dec);
    return d;
  endfunction

  assign eng_result = eng_fn(eng_state, eng_round, eng_dec);

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] d;
    logic         src;
    int           acc;
  } exp_t;

  exp_t         sbq[$];
  int           cyc = 0;
  logic         busy_m = 1'b0;
  logic         lg_m = 1'b1;
  logic         prev_rv = 1'b0;
  logic         prev_hs = 1'b0;
  logic [127:0] prev_rd = '0;

  function automatic logic [1:0] predict(input logic b, input logic v0, input logic v1, input logic lg);
    if (b) return 2'b00;
`ifdef AES_SCHED_STRICT_PRIO_EN
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
`else
    if (v0 && v1) return lg ? 2'b01 : 2'b10;
    return {v1, v0};
`endif
  endfunction

  always @(posedge clk) begin
    logic       b, exp_rv, w;
    logic [1:0] pg;
    exp_t       e;
    cyc = cyc + 1;
    if (rst) begin
      sbq.delete();
      busy_m  = 1'b0;
      lg_m    = 1'b1;
      prev_rv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      b = busy_m;
      // Result appears NR+1 edges after the accept edge.
      exp_rv = b && (sbq.size() > 0) && (cyc >= sbq[0].acc + NR + 2);
      check("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
      if (rsp_valid && prev_rv && !prev_hs) check("rsp_hold", rsp_data, prev_rd);
      pg = predict(b, req0_valid, req1_valid, lg_m);
      check("req0_ready", 128'(req0_ready), 128'(pg[0]));
      check("req1_ready", 128'(req1_ready), 128'(pg[1]));
      if (exp_rv && rsp_valid && rsp_ready) begin
        check("rsp_data", rsp_data, sbq[0].d);
        check("rsp_src", 128'(rsp_src), 128'(sbq[0].src));
        void'(sbq.pop_front());
        busy_m = 1'b0;
      end
      if (pg != 2'b00) begin
        w = pg[1];
        e.d   = aes_ref(w ? req1_data : req0_data, w ? req1_dec : req0_dec);
        e.src = w;
        e.acc = cyc;
        sbq.push_back(e);
        busy_m = 1'b1;
        lg_m   = w;
      end
      prev_rv = rsp_valid;
      prev_rd = rsp_data;
      prev_hs = rsp_valid && rsp_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 80 && busy_m; i++) tick();
    check("drain", 128'(busy_m), 128'(0));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] d, hold_d;
    logic [3:0]   got_g, exp_g;
    int           k, n;

    rst = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_dec = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_dec = 1'b0; req1_data = '0;
    build_tables();
    expand_key(KEY);

    // Reset values, with both requesters asking so ready gating is exercised.
    #1 rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_eng_state", eng_state, 128'(0));
    check("rst_eng_round", 128'(eng_round), 128'(0));
    check("rst_eng_dec", 128'(eng_dec), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_src", 128'(rsp_src), 128'(0));
    check("rst_ready0", 128'(req0_ready), 128'(0));
    check("rst_ready1", 128'(req1_ready), 128'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    check("ref_fips_enc", aes_ref(PT, 1'b0), CT);

    // FIPS-197 C.1 encrypt on requester 0.
    req0_data = PT; req0_dec = 1'b0; req0_valid = 1'b1;
    #1 check("c1_ready0", 128'(req0_ready), 128'(1));
    tick();
    req0_valid = 1'b0; req0_data = rnd128();
    k = 0;
    while (!rsp_valid && k < 30) begin tick(); k++; end
    check("c1_latency", 128'(k), 128'(NR + 1));
    check("c1_data", rsp_data, CT);
    check("c1_src", 128'(rsp_src), 128'(0));
    tick();

    // Decrypt on requester 1, round index walks NR..0.
    req1_data = CT; req1_dec = 1'b1; req1_valid = 1'b1;
    #1 check("dec_ready1", 128'(req1_ready), 128'(1));
    tick();
    req1_valid = 1'b0; req1_dec = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      check("dec_round", 128'(eng_round), 128'(NR - i));
      tick();
    end
    check("dec_valid", 128'(rsp_valid), 128'(1));
    check("dec_data", rsp_data, PT);
    check("dec_src", 128'(rsp_src), 128'(1));
    check("dec_mode", 128'(eng_dec), 128'(1));
    tick();

    // Both valid continuously: four grants.
    req0_data = rnd128(); req1_data = rnd128();
    req0_dec = 1'b0; req1_dec = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0; got_g = '0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      #1;
      if (req0_ready) begin got_g[n] = 1'b0; n++; end
      else if (req1_ready) begin got_g[n] = 1'b1; n++; end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("arb_count", 128'(n), 128'(4));
`ifdef AES_SCHED_STRICT_PRIO_EN
    exp_g = 4'b0000;
`else
    exp_g = 4'b1010;
`endif
    check("arb_order", 128'(got_g), 128'(exp_g));
    drain();

    // Back-pressure: consumer not ready for 5 cycles in HOLD.
    rsp_ready = 1'b0;
    d = rnd128();
    req0_data = d; req0_dec = 1'b0; req0_valid = 1'b1;
    #1 check("bp_ready0", 128'(req0_ready), 128'(1));
    tick();
    req0_valid = 1'b0; req1_data = rnd128(); req1_valid = 1'b1;
    k = 0;
    while (!rsp_valid && k < 30) begin tick(); k++; end
    hold_d = rsp_data;
    check("bp_data", hold_d, aes_ref(d, 1'b0));
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 128'(rsp_valid), 128'(1));
      check("bp_stable", rsp_data, hold_d);
      check("bp_no_ready", 128'({req1_ready, req0_ready}), 128'(0));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    check("bp_released", 128'(rsp_valid), 128'(0));
    check("bp_bubble_grant", 128'(req1_ready), 128'(1));
    req1_valid = 1'b0;
    tick();

    // Reset while the job is at cnt=4.
    req0_data = rnd128(); req0_dec = 1'b0; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    repeat (4) tick();
    check("mid_round", 128'(eng_round), 128'(4));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_state", eng_state, 128'(0));
    check("mid_rst_data", rsp_data, 128'(0));
    check("mid_rst_round", 128'(eng_round), 128'(0));
    check("mid_rst_ctl", 128'({eng_dec, rsp_valid, rsp_src, req0_ready, req1_ready}), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) tick();
    check("mid_no_rsp", 128'(rsp_valid), 128'(0));
    req0_data = rnd128(); req1_data = rnd128();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mid_tie0", 128'(req0_ready), 128'(1));
    check("mid_tie1", 128'(req1_ready), 128'(0));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Short request pulse while busy is never taken.
    req1_data = rnd128(); req1_dec = 1'b1; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    repeat (3) tick();
    req0_data = rnd128(); req0_valid = 1'b1;
    #1 check("pulse_no_ready", 128'(req0_ready), 128'(0));
    tick();
    req0_valid = 1'b0;
    drain();
    repeat (20) tick();
    check("pulse_no_rsp", 128'(rsp_valid), 128'(0));

    // Randomised traffic; the scoreboard checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_dec   = 1'($urandom_range(0, 1));
      req1_dec   = 1'($urandom_range(0, 1));
      req0_data  = rnd128();
      req1_data  = rnd128();
      rsp_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
    check("sb_empty", 128'(sbq.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
